dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the processor's load/store path and a secondary DMA-style requester (loader, debug or peripheral port). Sits between the CPU datapath and `dmem` inside `computer_top`, driving the `MemWrite`/`DataAdr`/`WriteData` memory signals. The CPU has priority, and the DMA port is served in bounded bursts. A starvation counter guarantees the DMA port progress. The CPU is stalled (PC and register writes held) only while the DMA port owns memory.

## Interface
- `STARVE_LIMIT`, 4: consecutive cycles a DMA request may wait behind CPU accesses before it is forced in.
- `BURST_MAX`, 4: maximum DMA accesses per ownership period while the CPU is requesting.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  CPU load or store this cycle (`MemWrite | MemtoReg`).
- `cpu_we`  in  1  CPU store.
- `cpu_adr`  in  32  CPU byte address.
- `cpu_wdata`  in  32  CPU store data.
- `cpu_rdata`  out  32  load data to the CPU (equals `ReadData`).
- `cpu_stall`  out  1  hold PC and suppress register/memory writes this cycle.
- `dma_req`  in  1  DMA access pending; held until acked.
- `dma_we`  in  1  DMA write.
- `dma_adr`  in  32  DMA byte address.
- `dma_wdata`  in  32  DMA write data.
- `dma_rdata`  out  32  read data (equals `ReadData`).
- `dma_ack`  out  1  DMA access completes at this rising edge.
- `MemWrite`  out  1  dmem write enable.
- `DataAdr`  out  32  dmem address.
- `WriteData`  out  32  dmem write data.
- `ReadData`  in  32  dmem combinational read data.

## Operation
- Owner state register has two states: `S_CPU` (reset state) and `S_DMA`. Counters: `starve_cnt` (0..STARVE_LIMIT) and `burst_cnt` (0..BURST_MAX-1).
- **S_CPU behaviour**
  - Memory mux selects the CPU signals; `MemWrite = cpu_req & cpu_we`.
  - `cpu_stall = 0` and `dma_ack = 0`.
  - `starve_cnt` increments while `dma_req & cpu_req`, saturating at STARVE_LIMIT. It clears when `dma_req = 0`.
- **S_CPU → S_DMA** when `dma_req & (!cpu_req | starve_cnt == STARVE_LIMIT)`. On entry, `burst_cnt` and `starve_cnt` clear.
- **S_DMA behaviour**
  - Memory mux selects the DMA signals; `MemWrite = dma_req & dma_we`.
  - `dma_ack = dma_req` and `cpu_stall = cpu_req`.
  - Each ack increments `burst_cnt`, wrapping to 0 after BURST_MAX-1.
- **S_DMA → S_CPU** when either:
  - `dma_req = 0`, or
  - an ack occurs with `burst_cnt == BURST_MAX-1` and `cpu_req = 1`.
- If `cpu_req = 0`, the DMA port keeps ownership indefinitely, and `burst_cnt` simply wraps.
- Both read ports are driven with `ReadData` at all times. Data is valid only for the current owner.
- When nobody is requesting, the mux follows the owner, and `MemWrite = 0`.
- The memory side never writes for an unacked DMA request or a stalled CPU request.

## Timing
- CPU access latency is 0 cycles in `S_CPU`: the access completes at the same edge, compatible with single-cycle execution.
- DMA minimum latency is 1 cycle: `dma_req` rises in `S_CPU` with the CPU idle, and the ack arrives in the following cycle.
- Worst-case DMA wait is STARVE_LIMIT + 1 cycles.
- Worst-case CPU stall is BURST_MAX cycles per DMA period.
- Simultaneous requests:
  - In `S_CPU`, the CPU wins unless `starve_cnt == STARVE_LIMIT`.
  - In `S_DMA`, the DMA port wins until its burst ends.
- Reset, sampled at a rising edge:
  - Next state is `S_CPU`, and both counters are 0.
  - While `reset = 1`, the combinational outputs are forced: `MemWrite = 0`, `dma_ack = 0`, `cpu_stall = 0`.
  - Reset mid-burst aborts the burst; the in-flight DMA access is not acked and must be re-requested.
- The DMA port must hold `dma_adr`/`dma_we`/`dma_wdata` stable from `dma_req` rise until ack.

## Test plan
- Reset, then CPU store `cpu_adr=0x10`, `cpu_wdata=0x1234`, no DMA → `MemWrite=1`, `DataAdr=0x10`, `WriteData=0x1234` in the same cycle; `cpu_stall=0`.
- CPU idle, DMA read of `0x4` with `dmem` word 1 preloaded to `0x00000005` → `dma_ack` in cycle 2, `dma_rdata=0x00000005`, `MemWrite=0`.
- CPU requesting every cycle, DMA writing `0x8 ← 0xA` → DMA waits 4 cycles, then the ack arrives on the 5th cycle after `dma_req`; `cpu_stall=1` that cycle; `RAM[2]=0xA` afterwards.
- DMA burst of 6 words with `cpu_req` continuously high → exactly 4 acks, then one `S_CPU` cycle with `cpu_stall=0`. The remaining 2 words follow after the next starvation window.
- DMA burst of 6 words with the CPU idle → 6 consecutive acks and no return to `S_CPU` until `dma_req` drops.
- Assert `reset` during the 2nd DMA ack cycle → no ack and `MemWrite=0` that cycle; `S_CPU` with `cpu_stall=0` afterwards; a subsequent CPU store completes with 0 latency.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares single-port dmem between the CPU load/store path
// and a DMA-style port. CPU has priority; DMA gets bounded bursts plus starvation relief.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_adr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        MemWrite,
    output logic [31:0] DataAdr,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX - 1);

    typedef enum logic [0:0] {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } owner_e;

    owner_e        state_r;
    owner_e        state_nxt_s;
    logic [SW-1:0] starve_cnt_r;
    logic [SW-1:0] starve_nxt_s;
    logic [BW-1:0] burst_cnt_r;
    logic [BW-1:0] burst_nxt_s;
    logic          mem_write_s;
    logic          dma_ack_s;
    logic          cpu_stall_s;

    // Owner state and counters register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_CPU;
            starve_cnt_r <= {SW{1'b0}};
            burst_cnt_r  <= {BW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            burst_cnt_r  <= burst_nxt_s;
        end
    end

    // Ownership hand-over and counter updates
    always_comb begin
        state_nxt_s  = state_r;
        starve_nxt_s = starve_cnt_r;
        burst_nxt_s  = burst_cnt_r;
        case (state_r)
            S_CPU: begin
                if (dma_req && (!cpu_req || (starve_cnt_r == STARVE_TOP))) begin
                    state_nxt_s  = S_DMA;
                    starve_nxt_s = {SW{1'b0}};
                    burst_nxt_s  = {BW{1'b0}};
                end else if (dma_req) begin
                    if (starve_cnt_r != STARVE_TOP) begin
                        starve_nxt_s = starve_cnt_r + SW'(1);
                    end else begin
                        starve_nxt_s = starve_cnt_r;
                    end
                end else begin
                    starve_nxt_s = {SW{1'b0}};
                end
            end
            S_DMA: begin
                if (!dma_req) begin
                    state_nxt_s = S_CPU;
                end else if (burst_cnt_r == BURST_TOP) begin
                    // Burst boundary: yield only if the CPU is actually waiting
                    burst_nxt_s = {BW{1'b0}};
                    if (cpu_req) begin
                        state_nxt_s = S_CPU;
                    end else begin
                        state_nxt_s = S_DMA;
                    end
                end else begin
                    burst_nxt_s = burst_cnt_r + BW'(1);
                end
            end
            default: begin
                state_nxt_s  = S_CPU;
                starve_nxt_s = {SW{1'b0}};
                burst_nxt_s  = {BW{1'b0}};
            end
        endcase
    end

    // Memory mux and handshake outputs follow the current owner
    always_comb begin
        DataAdr     = cpu_adr;
        WriteData   = cpu_wdata;
        mem_write_s = 1'b0;
        dma_ack_s   = 1'b0;
        cpu_stall_s = 1'b0;
        case (state_r)
            S_CPU: begin
                mem_write_s = cpu_req & cpu_we;
            end
            S_DMA: begin
                DataAdr     = dma_adr;
                WriteData   = dma_wdata;
                mem_write_s = dma_req & dma_we;
                dma_ack_s   = dma_req;
                cpu_stall_s = cpu_req;
            end
            default: begin
                mem_write_s = 1'b0;
            end
        endcase
    end

    // Reset masks every side effect in the cycle it is asserted
    assign MemWrite  = mem_write_s & ~reset;
    assign dma_ack   = dma_ack_s & ~reset;
    assign cpu_stall = cpu_stall_s & ~reset;
    assign cpu_rdata = ReadData;
    assign dma_rdata = ReadData;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level ownership/memory reference model.
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int BURST_MAX    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_adr, dma_wdata, dma_rdata;
    logic        dma_ack;
    logic        MemWrite;
    logic [31:0] DataAdr, WriteData, ReadData;

    logic [31:0] ram     [16] = '{1: 32'h0000_0005, default: 32'h0};
    logic [31:0] ref_mem [16] = '{1: 32'h0000_0005, default: 32'h0};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns memory, how long DMA has waited, acks in this period
    bit          m_owns = 1'b0;
    int          m_wait = 0;
    int          m_acks = 0;
    logic        exp_mw, exp_ack, exp_stall;
    logic [31:0] exp_adr, exp_wd;

    always #5 clk = ~clk;

    assign ReadData = ram[DataAdr[5:2]];

    always @(posedge clk) begin
        if (MemWrite === 1'b1) ram[DataAdr[5:2]] <= WriteData;
    end

    dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData)
    );

    task automatic model_eval();
        exp_adr   = m_owns ? dma_adr : cpu_adr;
        exp_wd    = m_owns ? dma_wdata : cpu_wdata;
        exp_mw    = !reset && (m_owns ? (dma_req && dma_we) : (cpu_req && cpu_we));
        exp_ack   = !reset && m_owns && dma_req;
        exp_stall = !reset && m_owns && cpu_req;
    endtask

    // Advance one rising edge: memory and ownership follow the arbitration rules
    task automatic tick();
        @(posedge clk);
        model_eval();
        if (exp_mw) ref_mem[exp_adr[5:2]] = exp_wd;
        if (reset) begin
            m_owns = 1'b0; m_wait = 0; m_acks = 0;
        end else if (!m_owns) begin
            if (dma_req && (!cpu_req || m_wait == STARVE_LIMIT)) begin
                m_owns = 1'b1; m_wait = 0; m_acks = 0;
            end else if (dma_req) begin
                m_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : m_wait;
            end else begin
                m_wait = 0;
            end
        end else if (!dma_req) begin
            m_owns = 1'b0;
        end else begin
            m_acks = (m_acks + 1) % BURST_MAX;
            if (m_acks == 0 && cpu_req) m_owns = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_adr = 32'h0; dma_wdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h0; cpu_wdata = 32'hDEAD;
        dma_req = 1'b1; dma_we = 1'b1; dma_adr = 32'h4; dma_wdata = 32'h1;
        @(negedge clk);
        n_cmp++; if (MemWrite !== 1'b0) begin n_bad++; $display("FAIL reset_memwrite: got %b want 0", MemWrite); end
        n_cmp++; if (dma_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", dma_ack); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        tick(); tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (MemWrite !== 1'b0) begin n_bad++; $display("FAIL idle_memwrite: got %b want 0", MemWrite); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall: got %b want 0", cpu_stall); end
        tick();
    endtask

    task automatic test_cpu_store();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h10; cpu_wdata = 32'h1234;
        @(negedge clk);
        n_cmp++; if (MemWrite !== 1'b1) begin n_bad++; $display("FAIL cpu_store_we: got %b want 1", MemWrite); end
        n_cmp++; if (DataAdr !== 32'h10) begin n_bad++; $display("FAIL cpu_store_adr: got %h want 00000010", DataAdr); end
        n_cmp++; if (WriteData !== 32'h1234) begin n_bad++; $display("FAIL cpu_store_data: got %h want 00001234", WriteData); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL cpu_store_stall: got %b want 0", cpu_stall); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (ram[4] !== 32'h1234) begin n_bad++; $display("FAIL cpu_store_ram: got %h want 00001234", ram[4]); end
        tick();
    endtask

    task automatic test_dma_read();
        dma_req = 1'b1; dma_we = 1'b0; dma_adr = 32'h4; dma_wdata = 32'hFFFF;
        @(negedge clk);
        n_cmp++; if (dma_ack !== 1'b0) begin n_bad++; $display("FAIL dma_read_early_ack: got %b want 0", dma_ack); end
        tick();
        @(negedge clk);
        n_cmp++; if (dma_ack !== 1'b1) begin n_bad++; $display("FAIL dma_read_ack: got %b want 1", dma_ack); end
        n_cmp++; if (dma_rdata !== 32'h5) begin n_bad++; $display("FAIL dma_read_data: got %h want 00000005", dma_rdata); end
        n_cmp++; if (MemWrite !== 1'b0) begin n_bad++; $display("FAIL dma_read_we: got %b want 0", MemWrite); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_starve();
        int got = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h30;
        dma_req = 1'b1; dma_we = 1'b1; dma_adr = 32'h8; dma_wdata = 32'hA;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (dma_ack === 1'b1) begin
                got = n;
                n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL starve_stall: got %b want 1", cpu_stall); end
                n_cmp++; if (MemWrite !== 1'b1) begin n_bad++; $display("FAIL starve_we: got %b want 1", MemWrite); end
            end else begin
                n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL starve_wait_stall: got %b want 0 at cycle %0d", cpu_stall, n); end
            end
            tick();
            if (got >= 0) break;
        end
        dma_req = 1'b0;
        n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL starve_latency: got %0d want 5", got); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (ram[2] !== 32'hA) begin n_bad++; $display("FAIL starve_ram: got %h want 0000000a", ram[2]); end
        tick();
    endtask

    // Six DMA writes to 0x20.. with the CPU either busy or idle; returns the ack cycles
    task automatic run_burst(input logic busy, output int ack_at [6]);
        int k = 0;
        for (int i = 0; i < 6; i++) ack_at[i] = -1;
        cpu_req = busy; cpu_we = 1'b0; cpu_adr = 32'h3C;
        for (int n = 0; n < 60 && k < 6; n++) begin
            dma_req = 1'b1; dma_we = 1'b1;
            dma_adr = 32'h20 + 32'(k) * 32'd4; dma_wdata = 32'h100 + 32'(k);
            @(negedge clk);
            if (busy && n == 9) begin
                n_cmp++; if (dma_ack !== 1'b0 || cpu_stall !== 1'b0) begin n_bad++; $display("FAIL burst_yield: got ack %b stall %b want 0 0", dma_ack, cpu_stall); end
            end
            if (dma_ack === 1'b1) ack_at[k] = n;
            tick();
            if (ack_at[k] == n) k++;
        end
        dma_req = 1'b0;
        tick();
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_burst_busy();
        int ack_at [6];
        int want [6] = '{5, 6, 7, 8, 14, 15};
        run_burst(1'b1, ack_at);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (ack_at[i] !== want[i]) begin n_bad++; $display("FAIL burst_busy_ack%0d: got cycle %0d want %0d", i, ack_at[i], want[i]); end
        end
        n_cmp++; if (ram[13] !== 32'h105) begin n_bad++; $display("FAIL burst_busy_ram: got %h want 00000105", ram[13]); end
    endtask

    task automatic test_burst_idle();
        int ack_at [6];
        run_burst(1'b0, ack_at);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (ack_at[i] !== i + 1) begin n_bad++; $display("FAIL burst_idle_ack%0d: got cycle %0d want %0d", i, ack_at[i], i + 1); end
        end
    endtask

    task automatic test_reset_mid_burst();
        dma_req = 1'b1; dma_we = 1'b1; dma_adr = 32'h3C; dma_wdata = 32'hBEEF;
        tick();
        @(negedge clk);
        n_cmp++; if (dma_ack !== 1'b1) begin n_bad++; $display("FAIL rst_burst_first_ack: got %b want 1", dma_ack); end
        tick();
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
        @(negedge clk);
        n_cmp++; if (dma_ack !== 1'b0) begin n_bad++; $display("FAIL rst_burst_ack: got %b want 0", dma_ack); end
        n_cmp++; if (MemWrite !== 1'b0) begin n_bad++; $display("FAIL rst_burst_we: got %b want 0", MemWrite); end
        tick();
        reset = 1'b0; cpu_adr = 32'h18; cpu_wdata = 32'h5A5A;
        @(negedge clk);
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_stall: got %b want 0", cpu_stall); end
        n_cmp++; if (MemWrite !== 1'b1 || DataAdr !== 32'h18) begin n_bad++; $display("FAIL rst_cpu_store: got we %b adr %h want 1 00000018", MemWrite, DataAdr); end
        n_cmp++; if (dma_ack !== 1'b0) begin n_bad++; $display("FAIL rst_dma_held: got %b want 0", dma_ack); end
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (ram[6] !== 32'h5A5A) begin n_bad++; $display("FAIL rst_cpu_ram: got %h want 00005a5a", ram[6]); end
        tick();
        @(negedge clk);
        n_cmp++; if (dma_ack !== 1'b1) begin n_bad++; $display("FAIL rst_rerequest_ack: got %b want 1", dma_ack); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit   pending = 1'b0;
        int   wait_n  = 0;
        logic got_ack;
        for (int c = 0; c < 3000; c++) begin
            if (!pending && $urandom_range(0, 1) == 1) begin
                dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
                dma_adr = 32'($urandom_range(0, 15)) << 2; dma_wdata = $urandom;
                pending = 1'b1; wait_n = 0;
            end
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_adr   = 32'($urandom_range(0, 15)) << 2;
            cpu_wdata = $urandom;
            reset     = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            model_eval();
            n_cmp++; if (MemWrite !== exp_mw) begin n_bad++; $display("FAIL rnd_memwrite: got %b want %b cycle %0d", MemWrite, exp_mw, c); end
            n_cmp++; if (DataAdr !== exp_adr) begin n_bad++; $display("FAIL rnd_adr: got %h want %h cycle %0d", DataAdr, exp_adr, c); end
            n_cmp++; if (WriteData !== exp_wd) begin n_bad++; $display("FAIL rnd_wdata: got %h want %h cycle %0d", WriteData, exp_wd, c); end
            n_cmp++; if (dma_ack !== exp_ack) begin n_bad++; $display("FAIL rnd_ack: got %b want %b cycle %0d", dma_ack, exp_ack, c); end
            n_cmp++; if (cpu_stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall: got %b want %b cycle %0d", cpu_stall, exp_stall, c); end
            n_cmp++; if (cpu_rdata !== ref_mem[exp_adr[5:2]]) begin n_bad++; $display("FAIL rnd_cpu_rdata: got %h want %h cycle %0d", cpu_rdata, ref_mem[exp_adr[5:2]], c); end
            n_cmp++; if (dma_rdata !== ref_mem[exp_adr[5:2]]) begin n_bad++; $display("FAIL rnd_dma_rdata: got %h want %h cycle %0d", dma_rdata, ref_mem[exp_adr[5:2]], c); end
            if (pending && dma_ack === 1'b1) begin
                n_cmp++; if (wait_n > STARVE_LIMIT + 1) begin n_bad++; $display("FAIL rnd_dma_wait: got %0d want <= %0d", wait_n, STARVE_LIMIT + 1); end
            end
            got_ack = exp_ack;
            tick();
            if (got_ack) begin
                pending = 1'b0; dma_req = 1'b0;
            end else if (reset) begin
                wait_n = 0;
            end else if (pending) begin
                wait_n++;
            end
        end
        reset = 1'b0;
        n_cmp++; if (pending && wait_n > STARVE_LIMIT + 1) begin n_bad++; $display("FAIL rnd_final_wait: got %0d want <= %0d", wait_n, STARVE_LIMIT + 1); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_cpu_store();
        test_dma_read();
        test_starve();
        test_burst_busy();
        test_burst_idle();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
